// File: rtl/reg_writeback_if.sv
// Writeback handshake bundle: ALU/load producer inputs, register-file write port and LQ occupancy.
// The producer side holds the master modport; the writeback stage holds the slave modport.
interface reg_writeback_if #(
    parameter int LQ_DEPTH = 4
);
    localparam int CW = $clog2(LQ_DEPTH + 1);

    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd;
    logic [63:0]   alu_val;

    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_rd;
    logic [63:0]   mem_data;
    logic [1:0]    mem_size;
    logic          mem_unsigned;

    logic          write_sig;
    logic [4:0]    write_reg;
    logic [63:0]   write_val;
    logic [CW-1:0] lq_count;

    modport master (
        output alu_valid, alu_rd, alu_val,
        output mem_valid, mem_rd, mem_data, mem_size, mem_unsigned,
        input  alu_ready, mem_ready,
        input  write_sig, write_reg, write_val, lq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_val,
        input  mem_valid, mem_rd, mem_data, mem_size, mem_unsigned,
        output alu_ready, mem_ready,
        output write_sig, write_reg, write_val, lq_count
    );
endinterface

// File: rtl/reg_writeback.sv
// Writeback merge of ALU results and extended loads (via LQ FIFO) into one register write per cycle, latency 1.
// ALU wins unless starvation forces an LQ drain; mem_ready = LQ not full. WB_BYPASS_EN: idle-path load bypass.
module reg_writeback #(
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    reg_writeback_if.slave bus
);
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] val;
    } wb_t;

    wb_t           r_lq [LQ_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_lq_count;
    logic [SW-1:0] r_starve;
    logic          r_write_sig;
    logic [4:0]    r_write_reg;
    logic [63:0]   r_write_val;

    logic          w_lq_empty;
    logic          w_lq_full;
    logic          w_force;
    logic          w_alu_wr;
    logic          w_mem_acc;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_ext;
    wb_t           w_head;
    logic          w_nxt_sig;
    logic [4:0]    w_nxt_reg;
    logic [63:0]   w_nxt_val;

    assign w_lq_empty = (r_lq_count == '0);
    assign w_lq_full  = (r_lq_count == CW'(LQ_DEPTH));
    assign w_force    = (r_starve == SW'(STARVE_MAX)) && !w_lq_empty;

    assign bus.alu_ready = !w_force;
    assign bus.mem_ready = !w_lq_full;

    // rd==0 transfers still complete the handshake but produce no write
    assign w_alu_wr  = bus.alu_valid && !w_force && (bus.alu_rd != 5'd0);
    assign w_mem_acc = bus.mem_valid && !w_lq_full && (bus.mem_rd != 5'd0);

`ifdef WB_BYPASS_EN
    assign w_bypass = w_mem_acc && w_lq_empty && !w_alu_wr;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_mem_acc && !w_bypass;
    assign w_pop  = !w_alu_wr && !w_lq_empty;
    assign w_head = r_lq[r_rd_ptr];

    always_comb begin
        w_ext = bus.mem_data;
        case (bus.mem_size)
            2'd0: w_ext = bus.mem_unsigned ? {56'd0, bus.mem_data[7:0]}
                                           : {{56{bus.mem_data[7]}}, bus.mem_data[7:0]};
            2'd1: w_ext = bus.mem_unsigned ? {48'd0, bus.mem_data[15:0]}
                                           : {{48{bus.mem_data[15]}}, bus.mem_data[15:0]};
            2'd2: w_ext = bus.mem_unsigned ? {32'd0, bus.mem_data[31:0]}
                                           : {{32{bus.mem_data[31]}}, bus.mem_data[31:0]};
            default: w_ext = bus.mem_data;
        endcase
    end

    always_comb begin
        w_nxt_sig = 1'b0;
        w_nxt_reg = r_write_reg;
        w_nxt_val = r_write_val;
        if (w_alu_wr) begin
            w_nxt_sig = 1'b1;
            w_nxt_reg = bus.alu_rd;
            w_nxt_val = bus.alu_val;
        end else if (w_pop) begin
            w_nxt_sig = 1'b1;
            w_nxt_reg = w_head.rd;
            w_nxt_val = w_head.val;
        end else if (w_bypass) begin
            w_nxt_sig = 1'b1;
            w_nxt_reg = bus.mem_rd;
            w_nxt_val = w_ext;
        end
    end

    // Payload storage carries no reset; validity is tracked by pointers and count
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_lq[r_wr_ptr] <= '{rd: bus.mem_rd, val: w_ext};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_lq_count  <= '0;
            r_starve    <= '0;
            r_write_sig <= 1'b0;
            r_write_reg <= 5'd0;
            r_write_val <= 64'd0;
        end else begin
            r_write_sig <= w_nxt_sig;
            r_write_reg <= w_nxt_reg;
            r_write_val <= w_nxt_val;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_lq_count <= r_lq_count + CW'(1);
                2'b01:   r_lq_count <= r_lq_count - CW'(1);
                default: r_lq_count <= r_lq_count;
            endcase

            if (w_pop || w_lq_empty) begin
                r_starve <= '0;
            end else if (w_alu_wr && (r_starve != SW'(STARVE_MAX))) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    assign bus.write_sig = r_write_sig;
    assign bus.write_reg = r_write_reg;
    assign bus.write_val = r_write_val;
    assign bus.lq_count  = r_lq_count;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboarded bench for reg_writeback: directed ALU/load vectors, per-source expected-write queues.
module tb_reg_writeback;
    localparam int LQ_DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_writeback_if #(.LQ_DEPTH(LQ_DEPTH)) bus ();

    reg_writeback #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] val;
    } exp_t;

    exp_t alu_q[$];
    exp_t lq_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   alu_run = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Loads use rd 7 or rd>=16; ALU traffic uses the remaining nonzero indices.
    always @(negedge clk) begin
        exp_t e;
        bit   ld;
        if (!rst && bus.write_sig === 1'b1) begin
            ld = (bus.write_reg == 5'd7) || (bus.write_reg >= 5'd16);
            if ((ld && lq_q.size() == 0) || (!ld && alu_q.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d val 0x%0h expected no write",
                         bus.write_reg, bus.write_val);
            end else begin
                if (ld) e = lq_q.pop_front();
                else    e = alu_q.pop_front();
                chk("wb_reg", {59'd0, bus.write_reg}, {59'd0, e.rd});
                chk("wb_val", bus.write_val, e.val);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic alu_send(input logic [4:0] rd, input logic [63:0] val);
        bit rdy;
        int n;
        n = 0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_val   = val;
        do begin
            @(negedge clk);
            rdy = bus.alu_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 60);
        bus.alu_valid = 1'b0;
        chk("alu_accept", {63'd0, rdy}, 64'd1);
        if (rdy) begin
            if (rd != 5'd0) alu_q.push_back(exp_t'{rd, val});
            @(negedge clk);
            chk("alu_lat1_sig", {63'd0, bus.write_sig}, {63'd0, rd != 5'd0});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mem_send(input logic [4:0] rd, input logic [63:0] data, input logic [1:0] size,
                            input logic uns, input logic [63:0] expv, output int waits);
        bit rdy;
        waits = 0;
        bus.mem_valid    = 1'b1;
        bus.mem_rd       = rd;
        bus.mem_data     = data;
        bus.mem_size     = size;
        bus.mem_unsigned = uns;
        forever begin
            @(negedge clk);
            rdy = bus.mem_ready;
            @(posedge clk);
            #1;
            if (rdy || waits >= 60) break;
            waits++;
        end
        bus.mem_valid = 1'b0;
        chk("mem_accept", {63'd0, rdy}, 64'd1);
        if (rdy && rd != 5'd0) lq_q.push_back(exp_t'{rd, expv});
    endtask

    task automatic alu_stream();
        int n;
        bit rdy;
        n = 0;
        while (alu_run) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(1 + n % 6);
            bus.alu_val   = 64'hA000 + 64'(n);
            @(negedge clk);
            rdy = bus.alu_ready && !rst;
            if (rdy) alu_q.push_back(exp_t'{bus.alu_rd, bus.alu_val});
            @(posedge clk);
            #1;
            if (rdy) n++;
        end
        bus.alu_valid = 1'b0;
    endtask

    // Extension vectors: rd, data, size, unsigned, expected write value
    logic [4:0]  t_rd   [10] = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd0, 5'd24};
    logic [63:0] t_dat  [10] = '{64'h80, 64'h80, 64'h8000_0000, 64'h1234_8001, 64'h1234_8001,
                                 64'hFFFF_FFFF_F000_0000, 64'h8000_0000_0000_0001,
                                 64'h8000_0000_0000_0001, 64'hFF, 64'h7FFF};
    logic [1:0]  t_sz   [10] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    logic        t_uns  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] t_exp  [10] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_8000_0000,
                                 64'hFFFF_FFFF_FFFF_8001, 64'h8001, 64'h0000_0000_F000_0000,
                                 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'h0,
                                 64'hFFFF_FFFF_FFFF_FFFF};

    initial begin
        int          w;
        int          t;
        bit          rdy;
        logic [63:0] v;

        bus.alu_valid    = 1'b0;
        bus.alu_rd       = 5'd0;
        bus.alu_val      = 64'd0;
        bus.mem_valid    = 1'b0;
        bus.mem_rd       = 5'd0;
        bus.mem_data     = 64'd0;
        bus.mem_size     = 2'd0;
        bus.mem_unsigned = 1'b0;
        rst = 1'b1;
        cyc(2);

        chk("rst_write_sig", {63'd0, bus.write_sig}, 64'd0);
        chk("rst_write_reg", {59'd0, bus.write_reg}, 64'd0);
        chk("rst_write_val", bus.write_val, 64'd0);
        chk("rst_lq_count", {61'd0, bus.lq_count}, 64'd0);
        chk("rst_mem_ready", {63'd0, bus.mem_ready}, 64'd1);
        chk("rst_alu_ready", {63'd0, bus.alu_ready}, 64'd1);
        rst = 1'b0;
        cyc(1);

        // ALU only, including a discarded rd==0 result
        alu_send(5'd5, 64'h1234);
        alu_send(5'd0, 64'h99);
        alu_send(5'd9, 64'hDEAD_BEEF_0000_0001);
        cyc(2);

        // Load extension, one load at a time
        for (int i = 0; i < 10; i++) begin
            mem_send(t_rd[i], t_dat[i], t_sz[i], t_uns[i], t_exp[i], w);
            cyc(3);
        end
        chk("ext_lq_empty", {61'd0, bus.lq_count}, 64'd0);

        // Idle-path load latency
        mem_send(5'd7, 64'h77, 2'd3, 1'b0, 64'h77, w);
        @(negedge clk);
        chk("byp_lat1_sig", {63'd0, bus.write_sig}, {63'd0, BYP});
        chk("byp_lat1_cnt", {61'd0, bus.lq_count}, BYP ? 64'd0 : 64'd1);
        @(negedge clk);
        chk("byp_lat2_sig", {63'd0, bus.write_sig}, {63'd0, !BYP});
        cyc(2);

        // Starvation: ALU every cycle with one load queued alongside the first ALU result
        bus.alu_valid    = 1'b1;
        bus.alu_rd       = 5'd3;
        bus.alu_val      = 64'h300;
        bus.mem_valid    = 1'b1;
        bus.mem_rd       = 5'd25;
        bus.mem_data     = 64'h55;
        bus.mem_size     = 2'd3;
        bus.mem_unsigned = 1'b0;
        @(negedge clk);
        chk("st_alu_rdy0", {63'd0, bus.alu_ready}, 64'd1);
        chk("st_mem_rdy0", {63'd0, bus.mem_ready}, 64'd1);
        alu_q.push_back(exp_t'{5'd3, 64'h300});
        lq_q.push_back(exp_t'{5'd25, 64'h55});
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        v = 64'h301;
        for (int k = 1; k <= 10; k++) begin
            bus.alu_val = v;
            @(negedge clk);
            rdy = bus.alu_ready;
            chk("st_alu_rdy", {63'd0, rdy}, {63'd0, k != 9});
            if (k == 10) begin
                chk("st_drain_reg", {59'd0, bus.write_reg}, 64'd25);
                chk("st_lq_cnt", {61'd0, bus.lq_count}, 64'd0);
            end
            if (rdy) begin
                alu_q.push_back(exp_t'{5'd3, v});
                v = v + 64'd1;
            end
            @(posedge clk);
            #1;
        end
        bus.alu_valid = 1'b0;
        cyc(3);

        // Full LQ under continuous ALU traffic; fifth load waits for the forced drain
        alu_run = 1'b1;
        fork
            alu_stream();
        join_none
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            mem_send(5'(26 + i), 64'h1000 + 64'(i), 2'd3, 1'b0, 64'h1000 + 64'(i), w);
        end
        chk("full_cnt", {61'd0, bus.lq_count}, 64'd4);
        chk("full_mem_rdy", {63'd0, bus.mem_ready}, 64'd0);
        mem_send(5'd30, 64'h1004, 2'd3, 1'b0, 64'h1004, w);
        chk("full_wait_cycles", 64'(w), 64'd6);
        alu_run = 1'b0;
        t = 0;
        while (bus.lq_count != '0 && t < 100) begin
            cyc(1);
            t++;
        end
        chk("full_drained", {61'd0, bus.lq_count}, 64'd0);
        cyc(3);

        // Reset with three loads queued
        alu_run = 1'b1;
        fork
            alu_stream();
        join_none
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            mem_send(5'(16 + i), 64'h2000 + 64'(i), 2'd3, 1'b0, 64'h2000 + 64'(i), w);
        end
        chk("rq_pre_cnt", {61'd0, bus.lq_count}, 64'd3);
        rst = 1'b1;
        alu_run = 1'b0;
        #1;
        chk("rq_cnt", {61'd0, bus.lq_count}, 64'd0);
        chk("rq_write_sig", {63'd0, bus.write_sig}, 64'd0);
        chk("rq_mem_ready", {63'd0, bus.mem_ready}, 64'd1);
        cyc(2);
        alu_q.delete();
        lq_q.delete();
        rst = 1'b0;
        cyc(10);
        chk("rq_post_cnt", {61'd0, bus.lq_count}, 64'd0);

        chk("alu_q_empty", 64'(alu_q.size()), 64'd0);
        chk("lq_q_empty", 64'(lq_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
